// File: rtl/risc_pipe_core.sv
// rtl/risc_pipe_core.sv - five-stage pipelined mini-RISC core
// Full EX forwarding, load-use interlock, EX-resolved branches, HALT freeze, debug and counters.
module risc_pipe_core #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int IM_DEPTH = 64,
  parameter int DM_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        im_we,
  input  logic [$clog2(IM_DEPTH)-1:0] im_waddr,
  input  logic [31:0]                 im_wdata,
  input  logic [4:0]                  dbg_raddr,
  output logic [XLEN-1:0]             dbg_rdata,
  output logic                        halted,
  output logic [31:0]                 retire_cnt,
  output logic [31:0]                 cycle_cnt
);
  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);
  localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_JMP  = 6'd7;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_BEQ  = 6'd9;
  localparam logic [5:0] OP_MUL  = 6'd10;
  localparam logic [5:0] OP_DIV  = 6'd11;
  localparam logic [5:0] OP_XOR  = 6'd12;
  localparam logic [5:0] OP_NOR  = 6'd13;
  localparam logic [5:0] OP_HALT = 6'd14;

  function automatic logic op_writes(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW, OP_ADDI,
      OP_MUL, OP_DIV, OP_XOR, OP_NOR: op_writes = 1'b1;
      default:                        op_writes = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW, OP_SW, OP_ADDI,
      OP_BEQ, OP_MUL, OP_DIV, OP_XOR, OP_NOR: uses_rs1 = 1'b1;
      default:                                uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_MUL, OP_DIV, OP_XOR, OP_NOR: uses_rs2 = 1'b1;
      default:                        uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rd(input logic [5:0] op);
    uses_rd = (op == OP_SW) || (op == OP_BEQ);
  endfunction

  logic [31:0]     im [IM_DEPTH];
  logic [XLEN-1:0] dm [DM_DEPTH];
  logic [XLEN-1:0] rf [NREG];
  logic [IAW-1:0]  pc;

  logic            ifid_valid;
  logic [31:0]     ifid_instr;
  logic [IAW-1:0]  ifid_pc;

  logic            idex_valid;
  logic [5:0]      idex_op;
  logic [RW-1:0]   idex_rd, idex_rs1, idex_rs2;
  logic [XLEN-1:0] idex_a, idex_b, idex_c, idex_imm;
  logic [IAW-1:0]  idex_pc;

  logic            exmem_valid;
  logic [5:0]      exmem_op;
  logic [RW-1:0]   exmem_rd;
  logic [XLEN-1:0] exmem_res, exmem_sdata;
  logic [DAW-1:0]  exmem_addr;

  logic            memwb_valid;
  logic [5:0]      memwb_op;
  logic [RW-1:0]   memwb_rd;
  logic [XLEN-1:0] memwb_res;

  logic wb_we;
  assign wb_we = memwb_valid && op_writes(memwb_op) && (memwb_rd != '0);

  // ID decode; the RF read sees the value being written back in the same cycle
  function automatic logic [XLEN-1:0] rf_read(input logic [RW-1:0] idx);
    if (idx == '0)                       rf_read = '0;
    else if (wb_we && memwb_rd == idx)   rf_read = memwb_res;
    else                                 rf_read = rf[idx];
  endfunction

  logic [5:0]      id_op;
  logic [RW-1:0]   id_rd, id_rs1, id_rs2;
  logic [XLEN-1:0] id_imm, id_a, id_b, id_c;

  assign id_op  = ifid_instr[31:26];
  assign id_rd  = ifid_instr[21 +: RW];
  assign id_rs1 = ifid_instr[16 +: RW];
  assign id_rs2 = ifid_instr[11 +: RW];
  assign id_imm = XLEN'($signed(ifid_instr[15:0]));
  assign id_a   = rf_read(id_rs1);
  assign id_b   = rf_read(id_rs2);
  assign id_c   = rf_read(id_rd);

  // A load still in EX/MEM has no data yet; the interlock guarantees it is never needed there
  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] idx, input logic [XLEN-1:0] rv);
    if (idx == '0)
      fwd = rv;
    else if (exmem_valid && op_writes(exmem_op) && exmem_op != OP_LW && exmem_rd == idx)
      fwd = exmem_res;
    else if (memwb_valid && op_writes(memwb_op) && memwb_rd == idx)
      fwd = memwb_res;
    else
      fwd = rv;
  endfunction

  logic [XLEN-1:0] ex_a, ex_b, ex_c, ex_res;
  logic [DAW-1:0]  ex_addr;
  logic [IAW-1:0]  ex_target;
  logic            ex_taken;

  always_comb begin
    ex_a      = fwd(idex_rs1, idex_a);
    ex_b      = fwd(idex_rs2, idex_b);
    ex_c      = fwd(idex_rd, idex_c);
    ex_res    = '0;
    ex_addr   = DAW'(ex_a + idex_imm);
    ex_target = (idex_op == OP_JMP) ? IAW'(idex_imm) : idex_pc + IAW'(idex_imm);
    ex_taken  = idex_valid && ((idex_op == OP_JMP) || (idex_op == OP_BEQ && ex_c == ex_a));
    case (idex_op)
      OP_ADD:  ex_res = ex_a + ex_b;
      OP_SUB:  ex_res = ex_a - ex_b;
      OP_AND:  ex_res = ex_a & ex_b;
      OP_OR:   ex_res = ex_a | ex_b;
      OP_XOR:  ex_res = ex_a ^ ex_b;
      OP_NOR:  ex_res = ~(ex_a | ex_b);
      OP_MUL:  ex_res = ex_a * ex_b;
      OP_DIV:  ex_res = (ex_b == '0) ? '0 : ex_a / ex_b;
      OP_ADDI: ex_res = ex_a + idex_imm;
      default: ex_res = '0;
    endcase
  end

  logic ld_use, fetch_stop, dm_we;

  assign ld_use = idex_valid && idex_op == OP_LW && idex_rd != '0 && ifid_valid &&
                  ((uses_rs1(id_op) && id_rs1 == idex_rd) ||
                   (uses_rs2(id_op) && id_rs2 == idex_rd) ||
                   (uses_rd(id_op)  && id_rd  == idex_rd));

  // Once a HALT has been decoded, nothing younger may enter the pipe
  assign fetch_stop = (ifid_valid  && id_op    == OP_HALT) ||
                      (idex_valid  && idex_op  == OP_HALT) ||
                      (exmem_valid && exmem_op == OP_HALT) ||
                      (memwb_valid && memwb_op == OP_HALT);

  assign dm_we = !halted && exmem_valid && exmem_op == OP_SW;

  always_ff @(posedge clk) begin
    if (im_we) im[im_waddr] <= im_wdata;
    if (dm_we) dm[exmem_addr] <= exmem_sdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      ifid_valid  <= 1'b0;
      ifid_instr  <= '0;
      ifid_pc     <= '0;
      idex_valid  <= 1'b0;
      idex_op     <= '0;
      idex_rd     <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_a      <= '0;
      idex_b      <= '0;
      idex_c      <= '0;
      idex_imm    <= '0;
      idex_pc     <= '0;
      exmem_valid <= 1'b0;
      exmem_op    <= '0;
      exmem_rd    <= '0;
      exmem_res   <= '0;
      exmem_sdata <= '0;
      exmem_addr  <= '0;
      memwb_valid <= 1'b0;
      memwb_op    <= '0;
      memwb_rd    <= '0;
      memwb_res   <= '0;
      halted      <= 1'b0;
      retire_cnt  <= '0;
      cycle_cnt   <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (!halted) begin
      if (wb_we) rf[memwb_rd] <= memwb_res;
      if (memwb_valid) retire_cnt <= retire_cnt + 32'd1;
      if (memwb_valid && memwb_op == OP_HALT) halted <= 1'b1;
      cycle_cnt <= cycle_cnt + 32'd1;

      memwb_valid <= exmem_valid;
      memwb_op    <= exmem_op;
      memwb_rd    <= exmem_rd;
      memwb_res   <= (exmem_op == OP_LW) ? dm[exmem_addr] : exmem_res;

      exmem_valid <= idex_valid;
      exmem_op    <= idex_op;
      exmem_rd    <= idex_rd;
      exmem_res   <= ex_res;
      exmem_sdata <= ex_c;
      exmem_addr  <= ex_addr;

      if (ex_taken) begin
        pc         <= ex_target;
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
        idex_valid <= 1'b0;
        idex_op    <= '0;
        idex_rd    <= '0;
      end else if (ld_use) begin
        idex_valid <= 1'b0;
        idex_op    <= '0;
        idex_rd    <= '0;
      end else begin
        idex_valid <= ifid_valid;
        idex_op    <= id_op;
        idex_rd    <= id_rd;
        idex_rs1   <= id_rs1;
        idex_rs2   <= id_rs2;
        idex_a     <= id_a;
        idex_b     <= id_b;
        idex_c     <= id_c;
        idex_imm   <= id_imm;
        idex_pc    <= ifid_pc;
        if (fetch_stop) begin
          ifid_valid <= 1'b0;
          ifid_instr <= '0;
        end else begin
          ifid_valid <= 1'b1;
          ifid_instr <= im[pc];
          ifid_pc    <= pc;
          pc         <= pc + IAW'(1);
        end
      end
    end
  end

  assign dbg_rdata = (dbg_raddr == 5'd0 || 32'(dbg_raddr) >= 32'(NREG)) ? '0 :
                     rf[dbg_raddr[RW-1:0]];

endmodule

// File: doc/risc_pipe_core.md
# risc_pipe_core

Parametrised five-stage (IF/ID/EX/MEM/WB) RISC core, the next generation of our 32-bit pipelined CPU. It adds full EX-stage operand forwarding, a load-use interlock, base+offset addressing, hardwired R0, a HALT instruction, an external program-load port, a debug register read port and retire/cycle counters. It is the top-level compute block for the mini-RISC subsystem.

## Interface
- XLEN, 32, datapath and register width (>=16)
- NREG, 32, register count (power of 2, <=32)
- IM_DEPTH, 64, instruction words (power of 2)
- DM_DEPTH, 64, data words (power of 2)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- im_we  in  1  instruction-memory write strobe
- im_waddr  in  log2(IM_DEPTH)  instruction write address
- im_wdata  in  32  instruction word
- dbg_raddr  in  5  register to observe
- dbg_rdata  out  XLEN  R[dbg_raddr], combinational, 0 for R0 or index>=NREG
- halted  out  1  HALT has retired; core frozen
- retire_cnt  out  32  instructions retired (bubbles excluded)
- cycle_cnt  out  32  cycles since reset, stops when halted

## Operation
- Encoding: op[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0] sign-extended to XLEN.
- Opcodes: ADD 1, SUB 2, AND 3, OR 4, LW 5, SW 6, JMP 7, ADDI 8, BEQ 9, MUL 10, DIV 11, XOR 12, NOR 13, HALT 14; 0 and 15-63 are NOPs (no writeback).
- R-type: R[rd] = R[rs1] op R[rs2]. ADDI: R[rd] = R[rs1] + imm. MUL keeps low XLEN bits (unsigned). DIV unsigned, divisor 0 gives 0.
- LW: R[rd] = DM[(R[rs1]+imm) mod DM_DEPTH]. SW: DM[(R[rs1]+imm) mod DM_DEPTH] = R[rd].
- JMP: PC = imm mod IM_DEPTH. BEQ: if R[rd]==R[rs1], PC = (PC_beq + imm) mod IM_DEPTH.
- R0 reads 0 always; writes to R0 discarded. Register indices taken mod NREG.
- Sources per op: rs1 for all but JMP/HALT/NOP; rs2 for R-type; rd for SW and BEQ.
- Forwarding into EX, priority EX/MEM over MEM/WB over RF; never forward for source index 0. EX/MEM LW result is not forwardable (covered by interlock).
- RF write-before-read: ID sees value written in WB same cycle.
- Load-use interlock: LW in EX whose rd (nonzero) matches any used source of the instruction in ID -> hold PC and IF/ID one cycle, insert bubble into ID/EX.
- Branch/JMP resolved in EX: taken -> PC loaded, IF/ID and ID/EX squashed (2 bubbles). Flush has priority over interlock.
- HALT: in ID stops fetch (PC held, bubbles into IF/ID); cancelled if squashed by a taken branch in EX. On reaching WB, halted=1; all pipeline state, RF and DM frozen until reset.
- im_we writes IM any cycle, including during reset; fetch of the same address in that cycle returns old word.
- PC increments mod IM_DEPTH (wraps to 0).

## Timing
- Reset (async): PC=0, all pipeline registers bubble (op 0, rd 0), RF cleared, halted=0, retire_cnt=0, cycle_cnt=0. DM and IM not cleared. Reset mid-execution drops all in-flight instructions; no partial writeback.
- Latency: instruction fetched in cycle n writes RF at edge ending cycle n+4; dependent ALU ops issue back-to-back with zero stall.
- LW followed by dependent instruction: exactly 1 stall cycle; dependent two slots later: 0 stalls.
- Taken branch/JMP: 2 cycles penalty; not-taken BEQ: 0.
- retire_cnt increments at the WB edge of each non-bubble instruction, HALT included. cycle_cnt increments every edge while !halted; both wrap at 2^32.
- halted rises on the edge HALT leaves WB; stays high until rst.

## Test plan
- Back-to-back ALU: ADDI R1,R0,5; ADDI R2,R1,3; ADD R3,R1,R2; HALT -> R3=13, retire_cnt=4, no stalls (cycle_cnt=8).
- Load-use: SW R1 to DM[R0+4] with R1=7; LW R2,4(R0); ADD R3,R2,R2; HALT -> R3=14, exactly one bubble observed in ID/EX.
- Branch squash: BEQ R0,R0,+3 followed by ADDI R5,R0,1 and ADDI R6,R0,1, target ADDI R7,R0,9 -> R5=R6=0, R7=9.
- R0 and DIV: ADDI R0,R0,9; ADDI R1,R0,10; DIV R2,R1,R0; MUL R3,R1,R1 -> R0=0, R2=0, R3=100.
- Halt in branch shadow: JMP 6 then HALT at next slot, HALT at 6 -> first HALT squashed, halted rises only after the one at 6; cycle_cnt frozen afterwards.
- Async reset mid-run: assert rst between edges during loop -> all outputs 0 immediately, reload via im_we during reset, rerun matches golden.
